// File: rtl/cnn16_pkg.sv
// Shared constants and types for the CNN16 control unit: opcode values,
// datapath bus-source and ALU-operation codes, and the sequencer state enum.
package cnn16_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_JN  = 4'h6;
    localparam logic [3:0] OP_LDX = 4'h7;
    localparam logic [3:0] OP_LDY = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [4:0] BUS_DR   = 5'd0;
    localparam logic [4:0] BUS_AC   = 5'd1;
    localparam logic [4:0] BUS_PC   = 5'd3;
    localparam logic [4:0] BUS_MEM  = 5'd4;
    localparam logic [4:0] BUS_IR   = 5'd14;
    localparam logic [4:0] BUS_ZERO = 5'd31;

    // ALU operation codes, shared with alu_fpu_16bit
    localparam logic [3:0] ALU_PASS_B = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_DECODE,
        ST_EXEC0,
        ST_EXEC1,
        ST_HALT
    } state_e;

    // Opcodes 0x0..0x8 and 0xF are defined; 0x9..0xE are not.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LDY) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/cnn16_control_unit.sv
// CNN16 hardwired fetch/decode/execute sequencer. Drives the datapath
// strobes as a Moore decode of the current state and the latched opcode.
// Optional build macro CNN16_SINGLE_STEP_EN adds step/step_mode inputs that
// hold the machine in FETCH0 until step is raised.
module cnn16_control_unit
    import cnn16_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef CNN16_SINGLE_STEP_EN
    input  logic        step,
    input  logic        step_mode,
`endif
    input  logic [15:0] IR_Value,
    input  logic        zero,
    input  logic        neg,
    output logic        AC_Load,
    output logic        DR_Load,
    output logic        IR_Load,
    output logic        XREG_Load,
    output logic        YREG_Load,
    output logic        PC_Load,
    output logic        AR_Load,
    output logic        PC_Inc,
    output logic [3:0]  alu_sel,
    output logic [4:0]  bus_sel,
    output logic        Zero_Check_En,
    output logic        neg_check_en,
    output logic        mem_we,
    output logic        busy,
    output logic        halted,
    output logic        illegal_op
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       step_hold;

    // The address field is consumed by the datapath through the IR bus source.
    logic unused_addr;
    assign unused_addr = ^IR_Value[11:0];

`ifdef CNN16_SINGLE_STEP_EN
    assign step_hold = step_mode && !step;
`else
    assign step_hold = 1'b0;
`endif

    // Next-state and opcode-latch logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_FETCH0;
            end
            ST_FETCH0: begin
                if (!step_hold) state_d = ST_FETCH1;
            end
            ST_FETCH1: state_d = ST_DECODE;
            ST_DECODE: begin
                opcode_d = IR_Value[15:12];
                if (op_is_legal(IR_Value[15:12]))
                    state_d = ST_EXEC0;
                else
                    state_d = (HALT_ON_ILLEGAL != 0) ? ST_HALT : ST_FETCH0;
            end
            ST_EXEC0: begin
                case (opcode_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_JZ, OP_JN: state_d = ST_EXEC1;
                    OP_HLT:                               state_d = ST_HALT;
                    default:                              state_d = ST_FETCH0;
                endcase
            end
            ST_EXEC1: state_d = ST_FETCH0;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and opcode registers; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_LDA;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Moore output decode; flags read in EXEC1 were sampled by the datapath in EXEC0
    always_comb begin
        AC_Load       = 1'b0;
        DR_Load       = 1'b0;
        IR_Load       = 1'b0;
        XREG_Load     = 1'b0;
        YREG_Load     = 1'b0;
        PC_Load       = 1'b0;
        AR_Load       = 1'b0;
        PC_Inc        = 1'b0;
        alu_sel       = ALU_PASS_B;
        bus_sel       = BUS_ZERO;
        Zero_Check_En = 1'b0;
        neg_check_en  = 1'b0;
        mem_we        = 1'b0;
        illegal_op    = 1'b0;
        busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted        = (state_q == ST_HALT);
        unique case (state_q)
            ST_FETCH0: begin
                if (!step_hold) begin
                    bus_sel = BUS_PC;
                    AR_Load = 1'b1;
                end
            end
            ST_FETCH1: begin
                bus_sel = BUS_MEM;
                IR_Load = 1'b1;
                PC_Inc  = 1'b1;
            end
            ST_DECODE: begin
                bus_sel    = BUS_IR;
                AR_Load    = 1'b1;
                illegal_op = !op_is_legal(IR_Value[15:12]);
            end
            ST_EXEC0: begin
                case (opcode_q)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        bus_sel = BUS_MEM;
                        DR_Load = 1'b1;
                    end
                    OP_STA: begin
                        bus_sel = BUS_AC;
                        mem_we  = 1'b1;
                    end
                    OP_JMP: begin
                        bus_sel = BUS_IR;
                        PC_Load = 1'b1;
                    end
                    OP_JZ: begin
                        bus_sel       = BUS_AC;
                        Zero_Check_En = 1'b1;
                    end
                    OP_JN: begin
                        bus_sel      = BUS_AC;
                        neg_check_en = 1'b1;
                    end
                    OP_LDX: begin
                        bus_sel   = BUS_MEM;
                        XREG_Load = 1'b1;
                    end
                    OP_LDY: begin
                        bus_sel   = BUS_MEM;
                        YREG_Load = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EXEC1: begin
                case (opcode_q)
                    OP_LDA: begin
                        alu_sel = ALU_PASS_B;
                        AC_Load = 1'b1;
                    end
                    OP_ADD: begin
                        alu_sel = ALU_ADD;
                        AC_Load = 1'b1;
                    end
                    OP_SUB: begin
                        alu_sel = ALU_SUB;
                        AC_Load = 1'b1;
                    end
                    OP_JZ: begin
                        if (zero) begin
                            bus_sel = BUS_IR;
                            PC_Load = 1'b1;
                        end
                    end
                    OP_JN: begin
                        if (neg) begin
                            bus_sel = BUS_IR;
                            PC_Load = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cnn16_control_unit.sv
// Bench for cnn16_control_unit: a small CNN16 datapath and memory around the
// controller, checked instruction by instruction against an ISA-level model.
`timescale 1ns/1ps
module tb_cnn16_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;

    // main DUT (illegal opcodes execute as NOP)
    logic ac_ld, dr_ld, ir_ld, x_ld, y_ld, pc_ld, ar_ld, pc_inc;
    logic [3:0] alu_sel;
    logic [4:0] bus_sel;
    logic zchk, nchk, mem_we, busy, halted, illegal_op;

    // second DUT (illegal opcodes halt), fed the same inputs
    logic h_ac_ld, h_dr_ld, h_ir_ld, h_x_ld, h_y_ld, h_pc_ld, h_ar_ld, h_pc_inc;
    logic [3:0] h_alu_sel;
    logic [4:0] h_bus_sel;
    logic h_zchk, h_nchk, h_mem_we, h_busy, h_halted, h_illegal_op;

    // datapath harness state
    logic [15:0] mem [0:4095];
    logic [15:0] ac, dr, ir_r, xr, yr, bus, alu;
    logic [11:0] pc, ar;
    logic        zero_r, neg_r;

    // harness commands from the stimulus process
    logic        cmd_clear, cmd_poke, cmd_set;
    logic [11:0] poke_a, set_pc;
    logic [15:0] poke_d, set_ac;

    // ISA-level reference
    logic [15:0] ref_mem [0:4095];
    logic [15:0] ref_ac, ref_x, ref_y;
    logic [11:0] ref_pc;

    int n_chk = 0;
    int n_err = 0;
    int h_ill_seen = 0;

    localparam logic [22:0] IDLE_OUTS = {8'b0, 4'b0, 5'd31, 6'b000000};
    localparam logic [22:0] HALT_OUTS = {8'b0, 4'b0, 5'd31, 6'b000010};

    logic [22:0] outs, h_outs;
    assign outs   = {ac_ld, dr_ld, ir_ld, x_ld, y_ld, pc_ld, ar_ld, pc_inc,
                     alu_sel, bus_sel, zchk, nchk, mem_we, busy, halted, illegal_op};
    assign h_outs = {h_ac_ld, h_dr_ld, h_ir_ld, h_x_ld, h_y_ld, h_pc_ld, h_ar_ld, h_pc_inc,
                     h_alu_sel, h_bus_sel, h_zchk, h_nchk, h_mem_we, h_busy, h_halted, h_illegal_op};

    cnn16_control_unit #(.HALT_ON_ILLEGAL(0)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CNN16_SINGLE_STEP_EN
        .step(1'b0), .step_mode(1'b0),
`endif
        .IR_Value(ir_r), .zero(zero_r), .neg(neg_r),
        .AC_Load(ac_ld), .DR_Load(dr_ld), .IR_Load(ir_ld), .XREG_Load(x_ld),
        .YREG_Load(y_ld), .PC_Load(pc_ld), .AR_Load(ar_ld), .PC_Inc(pc_inc),
        .alu_sel(alu_sel), .bus_sel(bus_sel), .Zero_Check_En(zchk),
        .neg_check_en(nchk), .mem_we(mem_we), .busy(busy), .halted(halted),
        .illegal_op(illegal_op)
    );

    cnn16_control_unit #(.HALT_ON_ILLEGAL(1)) dut_h (
        .clk(clk), .rst(rst), .start(start),
`ifdef CNN16_SINGLE_STEP_EN
        .step(1'b0), .step_mode(1'b0),
`endif
        .IR_Value(ir_r), .zero(zero_r), .neg(neg_r),
        .AC_Load(h_ac_ld), .DR_Load(h_dr_ld), .IR_Load(h_ir_ld), .XREG_Load(h_x_ld),
        .YREG_Load(h_y_ld), .PC_Load(h_pc_ld), .AR_Load(h_ar_ld), .PC_Inc(h_pc_inc),
        .alu_sel(h_alu_sel), .bus_sel(h_bus_sel), .Zero_Check_En(h_zchk),
        .neg_check_en(h_nchk), .mem_we(h_mem_we), .busy(h_busy), .halted(h_halted),
        .illegal_op(h_illegal_op)
    );

    // datapath bus source and ALU
    always_comb begin
        case (bus_sel)
            5'd0:    bus = dr;
            5'd1:    bus = ac;
            5'd3:    bus = {4'h0, pc};
            5'd4:    bus = mem[ar];
            5'd14:   bus = ir_r;
            default: bus = 16'h0000;
        endcase
        case (alu_sel)
            4'd0:    alu = dr;
            4'd1:    alu = ac + dr;
            4'd2:    alu = ac - dr;
            default: alu = 16'h0000;
        endcase
    end

    // datapath registers and memory, plus bench preload commands
    always @(posedge clk) begin
        if (cmd_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        end else if (cmd_poke) begin
            mem[poke_a] <= poke_d;
        end else if (mem_we) begin
            mem[ar] <= bus;
        end
        if (cmd_set) begin
            pc     <= set_pc;
            ac     <= set_ac;
            xr     <= 16'h0000;
            yr     <= 16'h0000;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            if (pc_ld)       pc <= bus[11:0];
            else if (pc_inc) pc <= pc + 12'd1;
            if (ac_ld) ac <= alu;
            if (x_ld)  xr <= bus;
            if (y_ld)  yr <= bus;
            if (zchk)  zero_r <= (bus == 16'h0000);
            if (nchk)  neg_r  <= bus[15];
        end
        if (ar_ld) ar   <= bus[11:0];
        if (dr_ld) dr   <= bus;
        if (ir_ld) ir_r <= bus;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_outs", outs, IDLE_OUTS);
        chk("rst_outs_h", h_outs, IDLE_OUTS);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        cmd_clear = 1'b1;
        @(posedge clk); #1;
        cmd_clear = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        cmd_poke = 1'b1;
        poke_a = a;
        poke_d = d;
        @(posedge clk); #1;
        cmd_poke = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic set_regs(input logic [11:0] p, input logic [15:0] a);
        cmd_set = 1'b1;
        set_pc = p;
        set_ac = a;
        @(posedge clk); #1;
        cmd_set = 1'b0;
        ref_pc = p;
        ref_ac = a;
        ref_x = 16'h0000;
        ref_y = 16'h0000;
    endtask

    // Architectural effect of one instruction and its expected cycle count.
    task automatic ref_step(output int cyc, output bit hlt, output bit ill, output bit wr,
                            output logic [11:0] wa, output bit pcl);
        logic [15:0] ins;
        logic [11:0] a;
        ins = ref_mem[ref_pc];
        a = ins[11:0];
        ref_pc = ref_pc + 12'd1;
        hlt = 0; ill = 0; wr = 0; pcl = 0; wa = a; cyc = 4;
        case (ins[15:12])
            4'h0: begin ref_ac = ref_mem[a]; cyc = 5; end
            4'h1: begin ref_mem[a] = ref_ac; wr = 1; end
            4'h2: begin ref_ac = ref_ac + ref_mem[a]; cyc = 5; end
            4'h3: begin ref_ac = ref_ac - ref_mem[a]; cyc = 5; end
            4'h4: begin ref_pc = a; pcl = 1; end
            4'h5: begin cyc = 5; if (ref_ac == 16'h0000) begin ref_pc = a; pcl = 1; end end
            4'h6: begin cyc = 5; if (ref_ac[15]) begin ref_pc = a; pcl = 1; end end
            4'h7: ref_x = ref_mem[a];
            4'h8: ref_y = ref_mem[a];
            4'hF: hlt = 1;
            default: begin ill = 1; cyc = 3; end
        endcase
    endtask

    // Run n instructions, checking each at the next FETCH0 (or HALT).
    task automatic run_instrs(input int n, input bit do_start);
        int cyc, exp_cyc, n_we, n_pl, n_ill;
        bit hlt, ill, wr, pcl;
        logic [11:0] wa, we_addr;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            ref_step(exp_cyc, hlt, ill, wr, wa, pcl);
            cyc = 0; n_we = 0; n_pl = 0; n_ill = 0; we_addr = '0;
            do begin
                if (mem_we) begin n_we++; we_addr = ar; end
                if (pc_ld) n_pl++;
                if (illegal_op) n_ill++;
                if (h_illegal_op) h_ill_seen++;
                @(posedge clk); #1;
                cyc++;
            end while (!((ar_ld && bus_sel == 5'd3) || halted) && cyc < 12);
            chk("cycles", cyc, exp_cyc);
            chk("mem_we_cnt", n_we, wr ? 1 : 0);
            if (wr) chk("we_addr", we_addr, wa);
            chk("pc_load_cnt", n_pl, pcl ? 1 : 0);
            chk("illegal_cnt", n_ill, ill ? 1 : 0);
            chk("pc", pc, ref_pc);
            chk("ac", ac, ref_ac);
            chk("xreg", xr, ref_x);
            chk("yreg", yr, ref_y);
            chk("halted", halted, hlt);
            chk("busy", busy, !hlt);
            if (hlt && k < n - 1) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic check_mem_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        cmd_clear = 1'b0; cmd_poke = 1'b0; cmd_set = 1'b0;
        poke_a = '0; poke_d = '0; set_pc = '0; set_ac = '0;
        @(posedge clk); #1;

        // LDA from 0x100
        do_reset(); clear_mem();
        poke(12'h000, 16'h0100); poke(12'h100, 16'h0007);
        set_regs(12'h000, 16'h0000);
        run_instrs(1, 1);

        // LDA / ADD / STA
        do_reset(); clear_mem();
        poke(12'h000, 16'h0100); poke(12'h001, 16'h2101); poke(12'h002, 16'h1102);
        poke(12'h100, 16'h0005); poke(12'h101, 16'h0003);
        set_regs(12'h000, 16'h0000);
        run_instrs(3, 1);
        chk("sta_result", mem[12'h102], 16'h0008);

        // JZ taken and not taken
        do_reset(); clear_mem();
        poke(12'h000, 16'h5020);
        set_regs(12'h000, 16'h0000);
        run_instrs(1, 1);
        chk("jz_taken_pc", pc, 12'h020);
        do_reset();
        set_regs(12'h000, 16'h0005);
        run_instrs(1, 1);
        chk("jz_not_taken_pc", pc, 12'h001);

        // HLT, quiet hold, resume
        do_reset(); clear_mem();
        poke(12'h000, 16'hF000); poke(12'h001, 16'h0100); poke(12'h100, 16'h1234);
        set_regs(12'h000, 16'h0000);
        run_instrs(1, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("halt_hold", outs, HALT_OUTS);
        end
        run_instrs(1, 1);
        chk("resume_ac", ac, 16'h1234);

        // Undefined opcode: NOP on one controller, HALT on the other
        do_reset(); clear_mem();
        poke(12'h000, 16'hA123); poke(12'h001, 16'h0100); poke(12'h100, 16'h0042);
        set_regs(12'h000, 16'h0000);
        h_ill_seen = 0;
        run_instrs(1, 1);
        chk("illegal_halt_outs", h_outs, HALT_OUTS);
        chk("illegal_halt_pulse", h_ill_seen, 1);
        run_instrs(1, 0);

        // Reset during EX0 of ADD
        do_reset(); clear_mem();
        poke(12'h000, 16'h0100); poke(12'h001, 16'h2101);
        poke(12'h100, 16'h0055); poke(12'h101, 16'h0001);
        set_regs(12'h000, 16'h0000);
        run_instrs(1, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("ex0_of_add", {dr_ld, bus_sel}, {1'b1, 5'd4});
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outs", outs, IDLE_OUTS);
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_quiet", outs, IDLE_OUTS);
        chk("abort_ac", ac, 16'h0055);

        // Random programs
        for (int r = 0; r < 2; r++) begin
            do_reset(); clear_mem();
            for (int a = 0; a < 64; a++) begin
                logic [3:0] op;
                logic [11:0] ad;
                int sel;
                sel = $urandom_range(0, 10);
                op = (sel == 9) ? 4'hF : (sel == 10) ? 4'hA : 4'(sel);
                if (op == 4'h4 || op == 4'h5 || op == 4'h6)
                    ad = 12'($urandom_range(0, 63));
                else
                    ad = 12'h100 + 12'($urandom_range(0, 15));
                poke(12'(a), {op, ad});
            end
            for (int a = 0; a < 16; a++) begin
                logic [15:0] dv;
                dv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                poke(12'h100 + 12'(a), dv);
            end
            set_regs(12'h000, 16'($urandom));
            run_instrs(200, 1);
            check_mem_image();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "timeout");
    end

endmodule
